// File: rtl/laser_search_if.sv
// Controller-to-datapath bundle for the laser coverage search.
// cand_valid qualifies cand for one cycle; gain for it returns GAIN_LAT cycles later with no backpressure.
interface laser_search_if;
  logic       load_en;
  logic [5:0] pt_idx;
  logic       cand_valid;
  logic [7:0] cand;
  logic       excl_en;
  logic [7:0] excl;
  logic [5:0] gain;
  logic [3:0] c1x;
  logic [3:0] c1y;
  logic [3:0] c2x;
  logic [3:0] c2y;
  logic       done;

  modport master (
    output load_en, pt_idx, cand_valid, cand, excl_en, excl,
    output c1x, c1y, c2x, c2y, done,
    input  gain
  );

  modport slave (
    input  load_en, pt_idx, cand_valid, cand, excl_en, excl,
    input  c1x, c1y, c2x, c2y, done,
    output gain
  );
endinterface

// File: rtl/laser_search_ctrl.sv
// Sequencer: loads 40 points, then alternates C1/C2 best-gain scans over the 16x16 grid
// until a slot stops moving or the pass limit is hit, and publishes the centers.
module laser_search_ctrl #(
  parameter int GAIN_LAT = 1,
  parameter int MAX_PASS = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  laser_search_if.master m_bus,
  output logic [2:0]     o_dbg_state
);
  typedef enum logic [2:0] {S_LOAD, S_SCAN, S_WAIT, S_EVAL, S_OUT} state_t;

  state_t              r_state, w_state_n;
  logic                r_run;
  logic [8:0]          r_cnt, w_cnt_n;
  logic                r_init, r_slot;
  logic [3:0]          r_pass;
  logic [7:0]          r_c1, r_c2, r_best_idx;
  logic [5:0]          r_best_gain;
  logic [15:0]         r_res;
  logic [GAIN_LAT-1:0] r_tag_v, r_tag_seed;
  logic [7:0]          r_tag_idx [GAIN_LAT];

  logic [7:0] w_cur, w_oth, w_cand;
  logic       w_load, w_scan, w_seed, w_scan_last, w_stop, w_take;

  assign w_load      = r_run && (r_state == S_LOAD);
  assign w_scan      = r_run && (r_state == S_SCAN);
  assign w_cur       = r_slot ? r_c2 : r_c1;
  assign w_oth       = r_slot ? r_c1 : r_c2;
  // Refinement scans spend count 0 on the baseline, so the grid index lags the count by one.
  assign w_seed      = !r_init && (r_cnt == 9'd0);
  assign w_cand      = r_init ? r_cnt[7:0] : (w_seed ? w_cur : r_cnt[7:0] - 8'd1);
  assign w_scan_last = r_init ? (r_cnt == 9'd255) : (r_cnt == 9'd256);
  assign w_stop      = !r_init && ((r_best_idx == w_cur) || (r_pass == 4'(MAX_PASS - 1)));
  assign w_take      = r_tag_v[GAIN_LAT-1] &&
                       (r_tag_seed[GAIN_LAT-1] || (m_bus.gain > r_best_gain));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (r_run) begin
      case (r_state)
        S_LOAD: begin
          w_cnt_n = r_cnt + 9'd1;
          if (r_cnt == 9'd39) begin
            w_state_n = S_SCAN;
            w_cnt_n   = '0;
          end
        end
        S_SCAN: begin
          w_cnt_n = r_cnt + 9'd1;
          if (w_scan_last) begin
            w_state_n = S_WAIT;
            w_cnt_n   = '0;
          end
        end
        S_WAIT: begin
          w_cnt_n = r_cnt + 9'd1;
          if (r_cnt == 9'(GAIN_LAT - 1)) begin
            w_state_n = S_EVAL;
            w_cnt_n   = '0;
          end
        end
        S_EVAL: begin
          w_cnt_n   = '0;
          w_state_n = w_stop ? S_OUT : S_SCAN;
        end
        S_OUT: begin
          w_cnt_n   = '0;
          w_state_n = S_LOAD;
        end
        default: begin
          w_cnt_n   = '0;
          w_state_n = S_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_init      <= 1'b1;
      r_slot      <= 1'b0;
      r_pass      <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_best_idx  <= '0;
      r_best_gain <= '0;
      r_res       <= '0;
      r_tag_v     <= '0;
      r_tag_seed  <= '0;
      for (int i = 0; i < GAIN_LAT; i++) r_tag_idx[i] <= '0;
    end else begin
      r_tag_v[0]    <= w_scan;
      r_tag_seed[0] <= w_scan && w_seed;
      r_tag_idx[0]  <= w_cand;
      for (int i = 1; i < GAIN_LAT; i++) begin
        r_tag_v[i]    <= r_tag_v[i-1];
        r_tag_seed[i] <= r_tag_seed[i-1];
        r_tag_idx[i]  <= r_tag_idx[i-1];
      end
      if (w_take) begin
        r_best_gain <= m_bus.gain;
        r_best_idx  <= r_tag_idx[GAIN_LAT-1];
      end
      if (r_run) begin
        case (r_state)
          S_LOAD: begin
            r_init      <= 1'b1;
            r_slot      <= 1'b0;
            r_pass      <= '0;
            r_c2        <= '0;
            r_best_gain <= '0;
            r_best_idx  <= '0;
          end
          S_EVAL: begin
            if (r_slot) r_c2 <= r_best_idx;
            else        r_c1 <= r_best_idx;
            r_best_gain <= '0;
            r_best_idx  <= '0;
            if (r_init) begin
              r_init <= 1'b0;
              r_slot <= 1'b1;
            end else if (w_stop) begin
              r_res <= r_slot ? {r_best_idx, r_c1} : {r_c2, r_best_idx};
            end else begin
              r_slot <= !r_slot;
              r_pass <= r_pass + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign m_bus.load_en    = w_load;
  assign m_bus.pt_idx     = w_load ? r_cnt[5:0] : 6'd0;
  assign m_bus.cand_valid = w_scan;
  assign m_bus.cand       = w_scan ? w_cand : 8'd0;
  assign m_bus.excl_en    = r_run && !r_init && ((r_state == S_SCAN) || (r_state == S_WAIT));
  assign m_bus.excl       = m_bus.excl_en ? w_oth : 8'd0;
  assign m_bus.done       = r_run && (r_state == S_OUT);
  assign m_bus.c1x        = r_res[3:0];
  assign m_bus.c1y        = r_res[7:4];
  assign m_bus.c2x        = r_res[11:8];
  assign m_bus.c2y        = r_res[15:12];
  assign o_dbg_state      = r_state;
endmodule
